lc3_operand_regfile: RTL and testbench
======================================

// Module: lc3_operand_regfile
// PURPOSE
//  Operand source and result sink for the LC-3 datapath ALU: 8 x 16-bit general register file,
//  SR1/SR2/imm5 operand select, DR write-back from BUS, NZP condition codes and BEN branch flag.
//  Drives the ALU A (SR1_OUT) and B (SR2_OUT) inputs; captures ALU/bus results on LD_REG.
//  Sits between the IR/control FSM and the ALU; all state updates on the rising Clk edge.
// PARAMETERS
//  DATA_W    16   register/bus width (only 16 is supported for LC-3)
//  NUM_REGS  8    number of general registers (fixed 8; index width 3)
// PORTS
//  Clk      in   1   system clock, all state on rising edge
//  Reset    in   1   synchronous, active-high reset
//  IR       in   16  current instruction register
//  BUS      in   16  datapath bus (write-back data, CC source)
//  LD_REG   in   1   write BUS into register selected by DRMUX
//  LD_CC    in   1   update NZP from BUS
//  LD_BEN   in   1   latch branch-enable from IR[11:9] & NZP
//  DRMUX    in   1   0: DR=IR[11:9]  1: DR=R7 (3'b111)
//  SR1MUX   in   1   0: SR1=IR[11:9] 1: SR1=IR[8:6]
//  SR2MUX   in   1   0: B=R[IR[2:0]] 1: B=SEXT(IR[4:0])
//  SR1_OUT  out  16  ALU A operand = R[SR1]
//  SR2_OUT  out  16  ALU B operand per SR2MUX
//  NZP      out  3   condition codes {N,Z,P}, registered
//  BEN      out  1   branch enable, registered
// BEHAVIOUR
//  - Reset (sync, priority over all loads): R0..R7 <= 16'h0000; NZP <= 3'b010; BEN <= 0.
//  - Reads combinational, zero latency: SR1_OUT/SR2_OUT follow IR, muxes and array same cycle.
//  - No write bypass: write on edge k visible on SR*_OUT after edge k (read of DR in the
//    write cycle returns the old value).
//  - SEXT: SR2_OUT = {{11{IR[4]}}, IR[4:0]} when SR2MUX=1.
//  - LD_REG=1: R[DR] <= BUS at edge; DR from DRMUX sampled in that cycle. LD_REG=0: array holds.
//  - LD_CC=1: N=BUS[15]; Z=(BUS==0); P=!N&&!Z. Exactly one bit set after any CC load.
//  - LD_BEN=1: BEN <= (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) using NZP register value BEFORE the edge.
//  - LD_CC and LD_BEN same cycle: BEN uses old NZP; NZP takes new value.
//  - LD_REG and LD_CC same cycle: independent; both sample the same BUS value.
//  - All loads deasserted: NZP, BEN, registers hold indefinitely.
//  - Reset asserted with loads active: reset wins; no write occurs that cycle.
//  - Control FSM: 1-state register-transfer block, no internal sequencing; no X on outputs
//    after first reset edge.
// TESTING
//  1 Reset: Reset=1 one edge -> all R=0, NZP=3'b010, BEN=0; SR1_OUT=SR2_OUT=0 for any IR.
//  2 Write/read: IR[11:9]=3, DRMUX=0, BUS=16'hBEEF, LD_REG=1 one edge -> SR1MUX=0 gives
//    SR1_OUT=16'hBEEF; same-cycle read before edge returns 16'h0000.
//  3 R7/imm: DRMUX=1, BUS=16'h1234, LD_REG -> R7=16'h1234; IR[4:0]=5'b10110, SR2MUX=1
//    -> SR2_OUT=16'hFFF6; IR[4:0]=5'b01111 -> 16'h000F.
//  4 CC: LD_CC with BUS=16'h8000 -> NZP=100; BUS=0 -> 010; BUS=16'h7FFF -> 001.
//  5 BEN: NZP=001, IR[11:9]=3'b001, LD_BEN -> BEN=1; same cycle LD_CC BUS=0 -> BEN=1, NZP=010;
//    next LD_BEN with IR[11:9]=001 -> BEN=0.
//  6 Reset mid-op: Reset=1 with LD_REG=1 BUS=16'hFFFF, LD_CC=1 -> R unchanged to 0, NZP=010.

Source files
------------

// File: rtl/lc3_operand_regfile.sv
// LC-3 operand register file: 8x16 GPRs with SR1/SR2/imm5 operand select,
// DR write-back from BUS, NZP condition codes and the BEN branch flag.
module lc3_operand_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   IR,
  input  logic [DATA_W-1:0]   BUS,
  input  logic                LD_REG,
  input  logic                LD_CC,
  input  logic                LD_BEN,
  input  logic                DRMUX,
  input  logic                SR1MUX,
  input  logic                SR2MUX,
  output logic [DATA_W-1:0]   SR1_OUT,
  output logic [DATA_W-1:0]   SR2_OUT,
  output logic [2:0]          NZP,
  output logic                BEN
);

  // Sign-extend the 5-bit immediate field to the datapath width.
  function automatic logic [DATA_W-1:0] sext5(input logic [4:0] imm);
    sext5 = {{(DATA_W-5){imm[4]}}, imm};
  endfunction

  logic [DATA_W-1:0] r_regs [0:NUM_REGS-1];
  logic [2:0]        r_nzp;
  logic              r_ben;

  logic [2:0]        w_dr;
  logic [2:0]        w_sr1;
  logic [DATA_W-1:0] w_sr1_data;
  logic [DATA_W-1:0] w_sr2_data;
  logic [2:0]        w_nzp_next;
  logic              w_ben_next;

  // Register selects, operand reads and condition-code/branch decode.
  always_comb begin
    w_dr       = 3'b000;
    w_sr1      = 3'b000;
    w_sr1_data = {DATA_W{1'b0}};
    w_sr2_data = {DATA_W{1'b0}};
    w_nzp_next = 3'b010;
    w_ben_next = 1'b0;

    if (DRMUX) begin
      w_dr = 3'b111;
    end else begin
      w_dr = IR[11:9];
    end

    if (SR1MUX) begin
      w_sr1 = IR[8:6];
    end else begin
      w_sr1 = IR[11:9];
    end

    w_sr1_data = r_regs[w_sr1];

    if (SR2MUX) begin
      w_sr2_data = sext5(IR[4:0]);
    end else begin
      w_sr2_data = r_regs[IR[2:0]];
    end

    if (BUS[DATA_W-1]) begin
      w_nzp_next = 3'b100;
    end else if (BUS == {DATA_W{1'b0}}) begin
      w_nzp_next = 3'b010;
    end else begin
      w_nzp_next = 3'b001;
    end

    // BEN is built from the NZP currently held, not the one being loaded.
    w_ben_next = |(IR[11:9] & r_nzp);
  end

  // Register array, condition codes and branch flag; reset overrides every load.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
      r_nzp <= 3'b010;
      r_ben <= 1'b0;
    end else begin
      if (LD_REG) begin
        r_regs[w_dr] <= BUS;
      end
      if (LD_CC) begin
        r_nzp <= w_nzp_next;
      end
      if (LD_BEN) begin
        r_ben <= w_ben_next;
      end
    end
  end

  assign SR1_OUT = w_sr1_data;
  assign SR2_OUT = w_sr2_data;
  assign NZP     = r_nzp;
  assign BEN     = r_ben;

endmodule

// File: tb/tb_lc3_operand_regfile.sv
// Self-checking bench for lc3_operand_regfile: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_lc3_operand_regfile;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR;
  logic [15:0] BUS;
  logic        LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX, SR2MUX;
  logic [15:0] SR1_OUT, SR2_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural model state.
  logic [15:0] m_regs [0:7];
  logic [2:0]  m_nzp;
  logic        m_ben;
  bit          m_valid = 1'b0;

  lc3_operand_regfile dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .BUS(BUS),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT), .NZP(NZP), .BEN(BEN)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0)       return 3'b100;
    else if (s == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  function automatic logic [15:0] exp_sr2();
    int imm;
    if (SR2MUX) begin
      imm = int'(IR[4:0]);
      if (imm >= 16) imm = imm - 32;
      return 16'(imm);
    end
    return m_regs[IR[2:0]];
  endfunction

  // Model update at each rising edge from the inputs held across that edge.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_nzp   = 3'b010;
      m_ben   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (LD_BEN)
        m_ben = (IR[11] && m_nzp[2]) || (IR[10] && m_nzp[1]) || (IR[9] && m_nzp[0]);
      if (LD_REG) m_regs[DRMUX ? 3 'd7 : IR[11:9]] = BUS;
      if (LD_CC)  m_nzp = cc_of(BUS);
    end
  end

  // Every-cycle comparison against the model once reset has been seen.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("sr1_out", SR1_OUT, m_regs[SR1MUX ? IR[8:6] : IR[11:9]]);
      chk("sr2_out", SR2_OUT, exp_sr2());
      chk("nzp", {13'd0, NZP}, {13'd0, m_nzp});
      chk("ben", {15'd0, BEN}, {15'd0, m_ben});
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
    DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; IR = 16'hFFFF; BUS = 16'hA5A5;
    LD_REG = 1'b1; LD_CC = 1'b1; LD_BEN = 1'b1;
    DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    step();

    // Reset state for a couple of IR patterns.
    Reset = 1'b0; idle(); IR = 16'h0E3F;
    #1;
    chk("rst_sr1", SR1_OUT, 16'h0000);
    chk("rst_sr2", SR2_OUT, 16'h0000);
    chk("rst_nzp", {13'd0, NZP}, 16'h0002);
    chk("rst_ben", {15'd0, BEN}, 16'h0000);
    IR = 16'h01C5; SR1MUX = 1'b1;
    #1;
    chk("rst_sr1_b", SR1_OUT, 16'h0000);

    // Write R3, no bypass in the write cycle.
    idle(); IR = 16'h0600; BUS = 16'hBEEF; LD_REG = 1'b1;
    #1;
    chk("wr_nobypass", SR1_OUT, 16'h0000);
    step();
    LD_REG = 1'b0;
    #1;
    chk("wr_r3", SR1_OUT, 16'hBEEF);

    // Write R7 through DRMUX, then immediate sign-extension.
    idle(); DRMUX = 1'b1; BUS = 16'h1234; LD_REG = 1'b1;
    step();
    idle(); IR = 16'h01D6; SR1MUX = 1'b1; SR2MUX = 1'b1;
    #1;
    chk("wr_r7", SR1_OUT, 16'h1234);
    chk("imm_neg", SR2_OUT, 16'hFFF6);
    IR = 16'h01CF;
    #1;
    chk("imm_pos", SR2_OUT, 16'h000F);
    SR2MUX = 1'b0; IR = 16'h0003;
    #1;
    chk("sr2_reg", SR2_OUT, 16'hBEEF);

    // Condition codes.
    idle(); LD_CC = 1'b1; BUS = 16'h8000; step();
    chk("cc_neg", {13'd0, NZP}, 16'h0004);
    BUS = 16'h0000; step();
    chk("cc_zero", {13'd0, NZP}, 16'h0002);
    BUS = 16'h7FFF; step();
    chk("cc_pos", {13'd0, NZP}, 16'h0001);

    // BEN uses NZP held before the edge even when CC loads together.
    idle(); IR = 16'h0200; LD_BEN = 1'b1; LD_CC = 1'b1; BUS = 16'h0000; step();
    chk("ben_old_cc", {15'd0, BEN}, 16'h0001);
    chk("ben_new_nzp", {13'd0, NZP}, 16'h0002);
    LD_CC = 1'b0; step();
    chk("ben_clear", {15'd0, BEN}, 16'h0000);

    // Reset beats simultaneous loads.
    idle(); Reset = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = 1'b1; BUS = 16'hFFFF;
    step();
    Reset = 1'b0; idle(); IR = 16'h07C0; SR1MUX = 1'b1;
    #1;
    chk("rst_mid_r7", SR1_OUT, 16'h0000);
    SR1MUX = 1'b0;
    #1;
    chk("rst_mid_r3", SR1_OUT, 16'h0000);
    chk("rst_mid_nzp", {13'd0, NZP}, 16'h0002);

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      Reset  = ($urandom_range(0, 99) == 0);
      IR     = 16'($urandom);
      LD_REG = 1'($urandom);
      LD_CC  = 1'($urandom);
      LD_BEN = 1'($urandom);
      DRMUX  = 1'($urandom);
      SR1MUX = 1'($urandom);
      SR2MUX = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       BUS = 16'h0000;
        1:       BUS = 16'h8000 | 16'($urandom);
        default: BUS = 16'($urandom);
      endcase
      step();
    end

    idle(); Reset = 1'b0;
    step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
